// File: rtl/ext_unit.sv
// Immediate-extension unit: sign/zero/upper/branch-shift extension feeding a
// registered 2-entry valid/ready output buffer with a wrapping transfer counter.
module ext_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [OUT_W-1:0] head_q, head_d;
    logic [OUT_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext;
    logic             in_xfer;
    logic             out_xfer;

    assign sext = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};

    always_comb begin
        ext = '0;
        case (in_mode)
            2'd0:    ext = sext;
            2'd1:    ext = {{(OUT_W-IN_W){1'b0}}, in_data};
            2'd2:    ext = {in_data, {(OUT_W-IN_W){1'b0}}};
            default: ext = sext << SHIFT;
        endcase
    end

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (in_xfer) state_d = S_ONE;
            S_ONE: begin
                if (in_xfer && !out_xfer)      state_d = S_TWO;
                else if (!in_xfer && out_xfer) state_d = S_EMPTY;
            end
            S_TWO:   if (out_xfer) state_d = S_ONE;
            default: state_d = S_EMPTY;
        endcase
    end

    // in_ready looks only at the state register (and rst), never at out_ready
    always_comb begin
        in_ready  = !rst && (state_q != S_TWO);
        out_valid = (state_q != S_EMPTY);
        out_data  = head_q;
        xfer_cnt  = cnt_q;
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (out_xfer) cnt_d = cnt_q + 1'b1;
        case (state_q)
            S_EMPTY: if (in_xfer) head_d = ext;
            S_ONE: begin
                if (in_xfer && out_xfer) head_d = ext;
                else if (in_xfer)        tail_d = ext;
            end
            S_TWO:   if (out_xfer) head_d = tail_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ext_unit.sv
// Bench for ext_unit: directed vectors plus random traffic checked against an
// arithmetic extension model and a queue model of the output buffer.
module tb_ext_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [15:0] xfer_cnt;

    int          total = 0;
    int          bad = 0;
    logic [31:0] q[$];
    int          exp_cnt = 0;

    ext_unit #(.IN_W(16), .OUT_W(32), .SHIFT(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_ext(input logic [15:0] d, input logic [1:0] m);
        longint v = longint'(d);
        longint r;
        if (v >= 32768) v = v - 65536;
        case (m)
            2'd0:    r = v;
            2'd1:    r = longint'(d);
            2'd2:    r = longint'(d) * 65536;
            default: r = v * 4;
        endcase
        return 32'(r);
    endfunction

    // Called at posedge+1; applies inputs, observes pre-edge state, advances one edge.
    task automatic cyc(input logic iv, input logic [15:0] d, input logic [1:0] m, input logic ordy,
                       output logic ir, output logic acc, output logic done, output logic [31:0] head);
        in_valid = iv; in_data = d; in_mode = m; out_ready = ordy;
        #2;
        ir = in_ready; acc = iv && in_ready; done = out_valid && ordy; head = out_data;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        total++; if (xfer_cnt !== 16'h0) begin bad++; $display("FAIL reset_xfer_cnt got=%h exp=0", xfer_cnt); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_modes();
        logic ir, acc, done;
        logic [31:0] head;
        logic [15:0] dv[5] = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF, 16'h4000};
        logic [1:0]  mv[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
        logic [31:0] ev[5] = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFFFC, 32'h00010000};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, dv[i], mv[i], 1'b1, ir, acc, done, head);
            total++; if (acc !== 1'b1) begin bad++; $display("FAIL mode_accept[%0d] got=%0b exp=1", i, acc); end
            total++; if (out_valid !== 1'b1 || out_data !== ev[i]) begin
                bad++; $display("FAIL mode_result[%0d] got=%0b/%h exp=1/%h", i, out_valid, out_data, ev[i]);
            end
        end
        cyc(1'b0, 16'h0, 2'd0, 1'b1, ir, acc, done, head);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mode_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic ir, acc, done;
        logic [31:0] head, exp;
        logic        c_taken = 1'b0;
        int          outs = 0;
        do_reset();
        cyc(1'b1, 16'hA5A5, 2'd0, 1'b0, ir, acc, done, head);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL bp_accept_a got=%0b exp=1", acc); end
        q.push_back(ref_ext(16'hA5A5, 2'd0));
        cyc(1'b1, 16'h0B0B, 2'd1, 1'b0, ir, acc, done, head);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL bp_accept_b got=%0b exp=1", acc); end
        q.push_back(ref_ext(16'h0B0B, 2'd1));
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready got=%0b exp=0", in_ready); end
        cyc(1'b1, 16'hCC03, 2'd3, 1'b0, ir, acc, done, head);
        total++; if (acc !== 1'b0) begin bad++; $display("FAIL bp_hold_c got=%0b exp=0", acc); end
        total++; if (out_data !== q[0]) begin bad++; $display("FAIL bp_head_stable got=%h exp=%h", out_data, q[0]); end
        for (int i = 0; i < 10 && !(c_taken && q.size() == 0); i++) begin
            cyc(!c_taken, 16'hCC03, 2'd3, 1'b1, ir, acc, done, head);
            if (done) begin
                exp = q.pop_front(); exp_cnt++; outs++;
                total++; if (head !== exp) begin bad++; $display("FAIL bp_order[%0d] got=%h exp=%h", outs, head, exp); end
            end
            if (acc) begin q.push_back(ref_ext(16'hCC03, 2'd3)); c_taken = 1'b1; end
        end
        total++; if (outs != 3 || !c_taken) begin bad++; $display("FAIL bp_count got=%0d exp=3", outs); end
        total++; if (xfer_cnt !== 16'd3) begin bad++; $display("FAIL bp_xfer_cnt got=%0d exp=3", xfer_cnt); end
    endtask

    task automatic test_streaming();
        logic ir, acc, done;
        logic [31:0] head, exp;
        logic [15:0] d;
        logic [1:0]  m;
        int          errs = 0;
        do_reset();
        for (int i = 0; i <= 100; i++) begin
            d = 16'($urandom); m = 2'($urandom);
            cyc(i < 100, d, m, 1'b1, ir, acc, done, head);
            total++; if (ir !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%0b exp=1", i, ir); end
            if (done) begin
                exp = q.pop_front(); exp_cnt++;
                total++; if (head !== exp) begin bad++; errs++; if (errs < 5) $display("FAIL stream_data[%0d] got=%h exp=%h", i, head, exp); end
            end
            if (acc) q.push_back(ref_ext(d, m));
        end
        total++; if (xfer_cnt !== 16'd100 || out_valid !== 1'b0) begin
            bad++; $display("FAIL stream_xfer_cnt got=%0d/%0b exp=100/0", xfer_cnt, out_valid);
        end
    endtask

    task automatic test_random_mix();
        logic ir, acc, done;
        logic [31:0] head, exp;
        logic [15:0] d;
        logic [1:0]  m;
        int          errs = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            d = 16'($urandom); m = 2'($urandom);
            cyc(1'($urandom), d, m, ($urandom_range(0, 3) != 0), ir, acc, done, head);
            total++; if (ir !== (q.size() < 2)) begin bad++; errs++; if (errs < 5) $display("FAIL mix_in_ready[%0d] got=%0b exp=%0b", i, ir, q.size() < 2); end
            if (done) begin
                if (q.size() == 0) begin
                    total++; bad++; errs++; if (errs < 5) $display("FAIL mix_spurious[%0d] got=valid exp=empty", i);
                end else begin
                    exp = q.pop_front(); exp_cnt++;
                    total++; if (head !== exp) begin bad++; errs++; if (errs < 5) $display("FAIL mix_data[%0d] got=%h exp=%h", i, head, exp); end
                end
            end
            if (acc) q.push_back(ref_ext(d, m));
            total++; if (xfer_cnt !== 16'(exp_cnt)) begin bad++; errs++; if (errs < 5) $display("FAIL mix_cnt[%0d] got=%0d exp=%0d", i, xfer_cnt, exp_cnt); end
        end
    endtask

    task automatic test_reset_mid();
        logic ir, acc, done;
        logic [31:0] head;
        do_reset();
        cyc(1'b1, 16'h1111, 2'd0, 1'b0, ir, acc, done, head);
        cyc(1'b1, 16'h2222, 2'd1, 1'b0, ir, acc, done, head);
        rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready got=%0b exp=0", in_ready); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0 || out_data !== 32'h0 || xfer_cnt !== 16'h0) begin
            bad++; $display("FAIL midrst_state got=%0b/%h/%h exp=0/0/0", out_valid, out_data, xfer_cnt);
        end
        rst = 1'b0; q.delete(); exp_cnt = 0;
        cyc(1'b1, 16'h8F00, 2'd2, 1'b1, ir, acc, done, head);
        total++; if (ir !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL midrst_first got=%0b/%0b exp=1/0", ir, done); end
        total++; if (out_data !== 32'h8F000000) begin bad++; $display("FAIL midrst_new_head got=%h exp=8f000000", out_data); end
        cyc(1'b0, 16'h0, 2'd0, 1'b1, ir, acc, done, head);
        total++; if (out_valid !== 1'b0 || xfer_cnt !== 16'd1) begin
            bad++; $display("FAIL midrst_no_stale got=%0b/%0d exp=0/1", out_valid, xfer_cnt);
        end
    endtask

    task automatic test_wrap();
        logic ir, acc, done;
        logic [31:0] head, exp;
        int          errs = 0;
        do_reset();
        for (int i = 0; i < 70000 && exp_cnt < 65535; i++) begin
            cyc(1'b1, 16'(i), 2'(i), 1'b1, ir, acc, done, head);
            if (done) begin
                exp = q.pop_front(); exp_cnt++;
                if (head !== exp) begin
                    bad++; errs++; if (errs < 5) $display("FAIL wrap_data[%0d] got=%h exp=%h", i, head, exp);
                end
            end
            if (acc) q.push_back(ref_ext(16'(i), 2'(i)));
        end
        total++; if (xfer_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_ffff got=%h exp=ffff", xfer_cnt); end
        cyc(1'b0, 16'h0, 2'd0, 1'b1, ir, acc, done, head);
        total++; if (done !== 1'b1 || xfer_cnt !== 16'h0000) begin
            bad++; $display("FAIL wrap_zero got=%h exp=0000", xfer_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_backpressure();
        test_streaming();
        test_random_mix();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ext_unit.md
# ext_unit

Parametrised, handshaked immediate-extension unit for the datapath's decode/execute boundary. It accepts an IN_W-bit immediate plus a mode select and produces an OUT_W-bit operand. Modes are sign-extend, zero-extend, upper-place, or sign-extend-and-shift for branch offsets. Results pass through a registered 2-entry output buffer with valid/ready flow control, so downstream stalls never drop or reorder operands. A wrapping transfer counter supports pipeline performance monitoring.

## Interface

Parameters:
- IN_W, 16, input immediate width; ≥ 2.
- OUT_W, 32, output width; must satisfy OUT_W > IN_W + SHIFT.
- SHIFT, 2, left-shift amount applied in mode 3.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset: synchronous, active-high.
- in_valid  input  1  producer presents in_data/in_mode.
- in_ready  output  1  unit can accept; depends only on registered state.
- in_data  input  IN_W  immediate value.
- in_mode  input  2  0 = sign-ext, 1 = zero-ext, 2 = upper, 3 = sign-ext << SHIFT.
- out_valid  output  1  out_data holds a valid result.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  OUT_W  extended result, head of buffer.
- xfer_cnt  output  CNT_W  count of completed output transfers; wraps.

## Operation

- Input transfer: in_valid && in_ready at a rising edge.
- Output transfer: out_valid && out_ready at a rising edge.
- Extension, computed combinationally from in_data and in_mode at acceptance:
  - mode 0: IN_W-bit in_data, upper OUT_W-IN_W bits replicate in_data[IN_W-1].
  - mode 1: upper OUT_W-IN_W bits are zero.
  - mode 2: in_data in bits [OUT_W-1 : OUT_W-IN_W], low bits zero.
  - mode 3: mode-0 result shifted left by SHIFT, zero fill; top SHIFT bits discarded.
- Buffer: 2 entries, FIFO order. State machine EMPTY / ONE / TWO:
  - EMPTY: in_ready=1, out_valid=0. On input transfer, go to ONE.
  - ONE: in_ready=1, out_valid=1.
    - input only: TWO.
    - output only: EMPTY.
    - both: stay in ONE; the new result becomes head in the same edge.
  - TWO: in_ready=0, out_valid=1. On output transfer, go to ONE; the second entry becomes head.
- out_data is the head entry. It holds stable while out_valid=1 and out_ready=0.
- in_data/in_mode are ignored when no input transfer occurs.
- xfer_cnt increments by 1 on every output transfer. It wraps from 2^CNT_W-1 to 0.

## Timing

- Latency: input accepted at edge N appears on out_data with out_valid=1 after edge N when the buffer was EMPTY.
- Throughput: one result per cycle with out_ready held at 1; steady state is ONE.
- No combinational path from out_ready to in_ready. in_ready drops for one or more cycles only when in TWO.
- Reset, sampled at a rising edge with rst=1:
  - State goes to EMPTY.
  - out_valid=0, out_data=0, xfer_cnt=0.
  - Both buffer entries are cleared to 0.
- While rst=1, in_ready=0. Input and output transfers are ignored and the counter does not increment.
- Reset mid-operation discards buffered results with no output transfer. The first cycle after rst deasserts is EMPTY with in_ready=1.
- With rst=0 and no transfers, all outputs hold their values.

## Test plan

All scenarios use defaults: IN_W=16, OUT_W=32, SHIFT=2.

- Modes 0 and 1, in_data=0x8001, out_ready=1 → out_data 0xFFFF8001 for mode 0, then 0x00008001 for mode 1. Each appears 1 cycle after acceptance.
- Modes 2 and 3: mode 2 with 0x1234 → 0x12340000. Mode 3 with 0xFFFF → 0xFFFFFFFC. Mode 3 with 0x4000 → 0x00010000.
- Backpressure, out_ready=0, offer A, B, C on consecutive cycles → A and B accepted; in_ready=0 after the second acceptance; C is held. Raise out_ready → outputs A, B, C in order, none lost or duplicated; xfer_cnt=3.
- Streaming: 100 back-to-back inputs with out_ready=1 → in_ready stays 1; outputs match the reference model each cycle; xfer_cnt=100.
- Reset mid-operation: buffer in TWO, assert rst for 1 cycle → out_valid=0, out_data=0, xfer_cnt=0, in_ready=0 during rst. The next accepted input appears alone, with no stale entries.
- Counter wrap: preload by streaming 65535 transfers, then 1 more → xfer_cnt reads 0xFFFF, then 0x0000.
